// File: rtl/counter_ctrl_pkg.sv
// Shared state encoding and default timing constants for the counter run/stop/clear controller.
package counter_ctrl_pkg;

  typedef enum logic [1:0] {
    STOP  = 2'd0,
    RUN   = 2'd1,
    CLEAR = 2'd2
  } state_e;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 50000;
  localparam int unsigned CNT_W_DEF           = 16;

endpackage

// File: rtl/button_debouncer.sv
// One front-panel button: 2-FF synchronizer, stable-sample debounce counter and a
// registered one-cycle pulse on the debounced rising edge (release is silent).
module button_debouncer
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_press
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             level_dly_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The level flips on the DEBOUNCE_CYCLES-th consecutive mismatching sample.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == TERM) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      press_q     <= 1'b0;
    end else begin
      sync1_q     <= i_btn;
      sync2_q     <= sync1_q;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_q;
      press_q     <= level_q & ~level_dly_q;
    end
  end

  assign o_press = press_q;

endmodule

// File: rtl/counter_run_ctrl.sv
// Run/stop/clear sequencer for the FND up-counter: debounced buttons drive a small FSM
// that gates divider ticks into o_cnt_en and issues a one-cycle clear. Option: AUTO_STOP_EN.
//   state | meaning
//   STOP  | counter frozen, waiting for a press
//   RUN   | divider ticks forwarded as count enables
//   CLEAR | one-cycle counter clear, then back to STOP
module counter_run_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_btn_runStop,
  input  logic       i_btn_clear,
  input  logic       i_tick,
`ifdef AUTO_STOP_EN
  input  logic       i_cnt_max,
`endif
  output logic       o_cnt_en,
  output logic       o_cnt_clr,
  output logic [1:0] o_state,
  output logic       o_run_led
);

  logic   rs_press, clr_press;
  logic   cnt_en_q, cnt_en_d;
  state_e state_q, state_d;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_run_stop (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_btn   (i_btn_runStop),
    .o_press (rs_press)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_clear (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_btn   (i_btn_clear),
    .o_press (clr_press)
  );

  always_comb begin
    state_d  = state_q;
    cnt_en_d = 1'b0;
    case (state_q)
      STOP: begin
        if (clr_press) begin
          state_d = CLEAR;
        end else if (rs_press) begin
          state_d = RUN;
        end
      end
      RUN: begin
`ifdef AUTO_STOP_EN
        cnt_en_d = i_tick & ~i_cnt_max;
        if (rs_press || (i_tick && i_cnt_max)) begin
          state_d = STOP;
        end
`else
        cnt_en_d = i_tick;
        if (rs_press) begin
          state_d = STOP;
        end
`endif
      end
      CLEAR:   state_d = STOP;
      default: state_d = STOP;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= STOP;
      cnt_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_en_q <= cnt_en_d;
    end
  end

  assign o_cnt_en  = cnt_en_q;
  assign o_cnt_clr = (state_q == CLEAR);
  assign o_state   = state_q;
  assign o_run_led = (state_q == RUN);

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Directed bench for counter_run_ctrl with DEBOUNCE_CYCLES=4: per-cycle vector table
// plus hand sequences for asynchronous reset and the AUTO_STOP_EN option.
module tb_counter_run_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rs = 1'b0;
  logic       cl = 1'b0;
  logic       tick = 1'b0;
`ifdef AUTO_STOP_EN
  logic       cnt_max = 1'b0;
`endif
  logic       cnt_en, cnt_clr, run_led;
  logic [1:0] state;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic       rs;
    logic       cl;
    logic       tick;
    logic [1:0] st;
    logic       en;
    logic       clr;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  counter_run_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_btn_runStop (rs),
    .i_btn_clear   (cl),
    .i_tick        (tick),
`ifdef AUTO_STOP_EN
    .i_cnt_max     (cnt_max),
`endif
    .o_cnt_en      (cnt_en),
    .o_cnt_clr     (cnt_clr),
    .o_state       (state),
    .o_run_led     (run_led)
  );

  function automatic logic [4:0] exp_of(logic [1:0] st, logic en, logic clr);
    return {st, en, clr, (st == 2'd1)};
  endfunction

  task automatic check(string name, logic [4:0] exp);
    logic [4:0] act;
    act = {state, cnt_en, cnt_clr, run_led};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got state=%0d en=%b clr=%b led=%b, expected state=%0d en=%b clr=%b led=%b",
               name, act[4:3], act[2], act[1], act[0], exp[4:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic push(int n, logic r, logic c, logic t, logic [1:0] s, logic e, logic k);
    vec_t v;
    v.rs = r; v.cl = c; v.tick = t; v.st = s; v.en = e; v.clr = k;
    repeat (n) vecs.push_back(v);
  endtask

  // Entered and left at a falling edge.
  task automatic apply(logic r, logic c, logic t, int n);
    rs = r; cl = c; tick = t;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    #2 rst = 1'b1;
    #1 check("reset_async", exp_of(2'd0, 1'b0, 1'b0));
    @(negedge clk);
    check("reset_hold", exp_of(2'd0, 1'b0, 1'b0));
    rst = 1'b0;

    // idle after reset with ticks
    push(3, 0,0,1, 0,0,0);
    // runStop held 20 cycles: RUN at row 7, tick on row 7 not counted
    push(7, 1,0,0, 0,0,0);
    push(1, 1,0,1, 1,0,0);
    push(2, 1,0,0, 1,0,0);
    push(1, 1,0,1, 1,1,0);
    push(3, 1,0,0, 1,0,0);
    push(1, 1,0,1, 1,1,0);
    push(5, 1,0,0, 1,0,0);
    push(8, 0,0,0, 1,0,0);
    // second press: tick on the RUN->STOP cycle is still counted
    push(7, 1,0,0, 1,0,0);
    push(1, 1,0,1, 0,1,0);
    push(2, 1,0,1, 0,0,0);
    push(8, 0,0,0, 0,0,0);
    // clear in STOP, held: single CLEAR cycle
    push(7, 0,1,0, 0,0,0);
    push(1, 0,1,1, 2,0,1);
    push(4, 0,1,0, 0,0,0);
    push(8, 0,0,0, 0,0,0);
    // bounce: 2-cycle toggles, then a 3-cycle pulse
    repeat (3) begin
      push(2, 1,0,1, 0,0,0);
      push(2, 0,0,0, 0,0,0);
    end
    push(4, 0,0,0, 0,0,0);
    push(3, 1,0,0, 0,0,0);
    push(8, 0,0,1, 0,0,0);
    // clear in RUN is ignored
    push(7, 1,0,0, 0,0,0);
    push(1, 1,0,0, 1,0,0);
    push(8, 0,0,0, 1,0,0);
    push(8, 0,1,0, 1,0,0);
    push(8, 0,0,0, 1,0,0);
    // both in RUN -> STOP, no clear
    push(7, 1,1,0, 1,0,0);
    push(1, 1,1,0, 0,0,0);
    push(8, 0,0,0, 0,0,0);
    // both in STOP -> CLEAR then STOP
    push(7, 1,1,0, 0,0,0);
    push(1, 1,1,0, 2,0,1);
    push(1, 1,1,0, 0,0,0);
    push(8, 0,0,0, 0,0,0);

    foreach (vecs[i]) begin
      rs = vecs[i].rs; cl = vecs[i].cl; tick = vecs[i].tick;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d", i), exp_of(vecs[i].st, vecs[i].en, vecs[i].clr));
    end

    // reset while RUN with an enable pending
    apply(1, 0, 0, 8);
    check("run_entry", exp_of(2'd1, 1'b0, 1'b0));
    apply(0, 0, 1, 1);
    check("run_tick", exp_of(2'd1, 1'b1, 1'b0));
    tick = 1'b0;
    #2 rst = 1'b1;
    #1 check("rst_in_run", exp_of(2'd0, 1'b0, 1'b0));
    @(negedge clk);
    rst = 1'b0;
    apply(0, 0, 1, 8);
    check("post_rst_idle", exp_of(2'd0, 1'b0, 1'b0));

    // reset mid-debounce discards the partial count
    apply(1, 0, 0, 3);
    rst = 1'b1; rs = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    apply(1, 0, 0, 3);
    apply(0, 0, 0, 8);
    check("rst_mid_debounce", exp_of(2'd0, 1'b0, 1'b0));

    // reset during CLEAR
    apply(0, 1, 0, 8);
    check("clear_state", exp_of(2'd2, 1'b0, 1'b1));
    #2 rst = 1'b1;
    #1 check("rst_in_clear", exp_of(2'd0, 1'b0, 1'b0));
    cl = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    apply(0, 0, 0, 10);
    check("post_rst_clear", exp_of(2'd0, 1'b0, 1'b0));

`ifdef AUTO_STOP_EN
    apply(1, 0, 0, 8);
    check("as_run", exp_of(2'd1, 1'b0, 1'b0));
    apply(0, 0, 0, 8);
    cnt_max = 1'b0;
    apply(0, 0, 1, 1);
    check("as_tick_no_max", exp_of(2'd1, 1'b1, 1'b0));
    cnt_max = 1'b1;
    apply(0, 0, 1, 1);
    check("as_auto_stop", exp_of(2'd0, 1'b0, 1'b0));
    cnt_max = 1'b0;
    apply(0, 0, 1, 2);
    check("as_stays_stop", exp_of(2'd0, 1'b0, 1'b0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/counter_run_ctrl.md
Name: counter_run_ctrl

Overview:
- Button-driven run/stop/clear controller for the FND up-counter datapath (clock divider -> 14-bit BCD-range counter -> FND display).
- Debounces the front-panel buttons and sequences the counter through a small FSM.
- Emits a gated count-enable pulse (divider tick qualified by RUN) and a one-cycle synchronous clear to the counter.
- Sits between the board buttons, the clock-divider tick and the counter; runs entirely on the board clock.

Parameters:
- DEBOUNCE_CYCLES, 16'd50000, consecutive stable samples required before a debounced level changes (min 2).
- CNT_W, 16, width of the internal debounce counter; must hold DEBOUNCE_CYCLES.

Ports:
- i_clk  input  1  board clock; all logic on rising edge
- i_reset  input  1  asynchronous, active-high reset
- i_btn_runStop  input  1  raw, asynchronous run/stop button, active-high
- i_btn_clear  input  1  raw, asynchronous clear button, active-high
- i_tick  input  1  one-i_clk-cycle count tick from the clock divider, already in the i_clk domain
- o_cnt_en  output  1  count-enable pulse to counter: i_tick AND state==RUN, registered
- o_cnt_clr  output  1  one-cycle synchronous clear to counter
- o_state  output  2  current FSM state: 2'd0 STOP, 2'd1 RUN, 2'd2 CLEAR
- o_run_led  output  1  high while state==RUN

Behaviour:
- Reset (async, active-high) forces the following values immediately; release is sampled on the next i_clk edge:
  - state=STOP, all outputs 0
  - synchronizers, debounce counters, debounced levels and press pulses = 0
- Per-button path (identical for each button):
  - 2-FF synchronizer.
  - Debounce counter: clears whenever synced input equals the debounced level; otherwise increments. Reaching DEBOUNCE_CYCLES-1 flips the debounced level and clears the counter.
  - Press pulse: 1 cycle, registered, on the 0->1 edge of the debounced level only. Release generates no pulse.
  - Glitches shorter than DEBOUNCE_CYCLES produce no pulse.
- Latency: raw input held high from edge k gives a press pulse high during cycle k+DEBOUNCE_CYCLES+2. o_state updates on the following edge.
- FSM transitions, evaluated on press pulses:
  - STOP, runStop press -> RUN
  - STOP, clear press -> CLEAR. If both press in the same cycle, clear wins.
  - RUN, runStop press -> STOP
  - RUN, clear press -> ignored (stay RUN). Simultaneous presses in RUN -> STOP.
  - CLEAR -> STOP unconditionally after 1 cycle.
- o_cnt_clr = 1 exactly during the cycle state==CLEAR; otherwise 0.
- o_cnt_en is registered: high in cycle n+1 iff i_tick=1 and state==RUN in cycle n. A tick arriving in the same cycle as the state change to RUN is not counted; a tick in the cycle RUN->STOP is taken is counted.
- o_state and o_run_led are driven directly from the state register.
- Holding a button generates only one press. Repeat requires release (debounced) then re-press.
- Reset mid-debounce or mid-CLEAR aborts everything. No pulse survives reset.
- Unused encoding 2'd3 -> STOP on next edge.

Optional Feature:
- Macro AUTO_STOP_EN.
- Defined:
  - extra input i_cnt_max (1 bit): counter is at 9999.
  - In RUN, o_cnt_en is suppressed when i_cnt_max=1 and i_tick=1; FSM goes RUN -> STOP on that edge.
- Undefined: port absent; RUN continues and the counter wraps 9999->0 on its own.

Decomposition:
- Shared package counter_ctrl_pkg:
  - state typedef/localparams STOP=2'd0, RUN=2'd1, CLEAR=2'd2
  - default DEBOUNCE_CYCLES constant
- One sub-module, button_debouncer: synchronizer + debounce counter + press-pulse generator, parameterized by DEBOUNCE_CYCLES/CNT_W. Instantiated twice.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset: assert i_reset mid-cycle -> all outputs 0 immediately. Release -> state stays STOP with no tick effect.
- Clean runStop press held 20 cycles:
  - press pulse at edge k+6, o_state=1 at k+7
  - later i_tick pulses -> o_cnt_en high exactly one cycle after each tick
  - second press -> o_state=0 and o_cnt_en stays 0 on subsequent ticks
- Bounce: runStop toggling every 2 cycles for 12 cycles then low -> no state change. Then high 3 cycles only -> no change.
- Clear in STOP -> o_state=2 and o_cnt_clr=1 for exactly 1 cycle, then o_state=0. Clear in RUN -> no o_cnt_clr, stays RUN.
- Simultaneous press of both buttons:
  - in STOP -> CLEAR then STOP
  - in RUN -> STOP with no clear
- AUTO_STOP_EN build: RUN, i_cnt_max=1 with i_tick -> o_cnt_en stays 0 and o_state=0 next edge.
